serial_to_parallel5: RTL and testbench
======================================

Name: serial_to_parallel5

Overview:
- Upstream feeder for the 5-bit resettable enabled register.
- Collects a framed serial bit stream (start, 5 data bits, optional parity bit) into a 5-bit word.
- Presents the word on `data_out` and pulses `load_en` for one cycle, so the downstream register can capture `d_in=data_out` with `en=load_en`.
- Sets a parity error flag instead of loading when the received parity is wrong.

Parameters:
- PARITY_EN, 1: 1 = a parity bit follows the 5 data bits; 0 = no parity phase.
- ODD_PARITY, 0: 0 = even parity (parity bit = XOR of data bits); 1 = odd parity (parity bit = inverted XOR).
- MSB_FIRST, 0: 0 = first received bit lands in `data_out[0]`; 1 = first received bit lands in `data_out[4]`.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a frame; honoured only in IDLE.
- abort  input  1  drop the current frame and return to IDLE.
- bit_valid  input  1  `bit_in` is valid this cycle.
- bit_in  input  1  serial data or parity bit.
- busy  output  1  high in every state except IDLE.
- data_out  output  5  last successfully received word.
- load_en  output  1  one-cycle pulse when `data_out` carries a new word.
- parity_err  output  1  one-cycle pulse on parity mismatch.

Behaviour:
- Everything is registered on the rising edge of `clk`. Reset is synchronous and active-high; it dominates all other inputs.
- Reset values:
  - state = IDLE, bit counter = 0, shift register = 0.
  - `data_out` = 5'b00000, `load_en` = 0, `parity_err` = 0, `busy` = 0.
- States:
  - IDLE: `start` goes to SHIFT and clears the counter and shift register. `bit_valid` is ignored. If `start` and `bit_valid` arrive in the same cycle, the bit is NOT captured; the first data bit is expected on a later cycle.
  - SHIFT: each `bit_valid` shifts `bit_in` in and increments the counter (0..4). Cycles without `bit_valid` hold state; there is no timeout.
    - MSB_FIRST=0: shift right, new bit enters bit 4.
    - MSB_FIRST=1: shift left, new bit enters bit 0.
    - On the 5th accepted bit (counter=4): go to PARITY if PARITY_EN=1, else commit.
  - PARITY: the next `bit_valid` compares `bit_in` against the expected parity of the shift register.
    - Match: commit.
    - Mismatch: `parity_err`=1 for one cycle, `data_out` unchanged, `load_en` stays 0.
    - Either way, go to IDLE.
- Commit: in the cycle after the accepting edge, `data_out` = shift register, `load_en`=1 (exactly one cycle), state = IDLE.
  - Latency from the last data bit (PARITY_EN=0) or the parity bit to `load_en` high is one clock.
- `data_out` is stable between commits and keeps its last good value across errors and aborts.
- `abort`:
  - From SHIFT or PARITY: go to IDLE next cycle, counter cleared, no `load_en`, no `parity_err`.
  - If `abort` and the completing `bit_valid` arrive in the same cycle, `abort` wins and nothing is committed.
  - In IDLE, `abort` has no effect and beats `start` when both are asserted.
- `start` outside IDLE is ignored; it does not restart the frame.
- `load_en` and `parity_err` are never high together.
- A back-to-back frame may `start` in the same cycle that `load_en` is high, since the state is already IDLE.
- Reset mid-frame: the frame is discarded and all outputs return to their reset values, including `data_out`.

Decomposition:
- Shared package holds:
  - Width constant WORD_W = 5.
  - State encodings IDLE=2'b00, SHIFT=2'b01, PARITY=2'b10; 2'b11 is illegal and recovers to IDLE.
  - Counter width constant CNT_W = 3.
- One natural sub-module: `shift_reg5_dir`. It is a 5-bit shift register with shift enable, synchronous clear and a direction parameter.
  - Parity generation and the FSM stay in the top module.

Test Plan:
- Even parity, LSB-first. Stimulus: `start`, then bits 1,0,1,1,0, then parity 1. Response: `data_out`=5'b01101 one cycle later, `load_en` high exactly 1 cycle, `parity_err`=0, `busy` falls the same cycle.
- Parity error. Stimulus: same data bits with parity bit 0. Response: `parity_err` is a 1-cycle pulse, `load_en`=0, `data_out` keeps the prior value 5'b01101.
- MSB_FIRST=1, PARITY_EN=0. Stimulus: bits 1,0,0,0,1 with `bit_valid` gaps of 2 idle cycles. Response: `data_out`=5'b10001 one cycle after the 5th bit; bits are captured only when `bit_valid` is high.
- Abort on the 5th bit. Stimulus: `abort` asserted with the 5th `bit_valid` (bits 1,1,1,1,1). Response: no `load_en`, no `parity_err`, `busy`=0 next cycle, `data_out` unchanged.
- Start/bit collision and ignored start. Stimulus: `start`+`bit_valid`(1) in IDLE, then `start` asserted again mid-frame, then bits 0,0,0,0,0 with parity 0. Response: the first bit is dropped and the second `start` is ignored; `data_out`=5'b00000 with `load_en` pulse.
- Reset mid-frame. Stimulus: assert `reset` after 3 bits. Response: next cycle `busy`=0, `data_out`=0. A following full frame 0,1,0,1,0 with parity 0 yields 5'b01010.

Source files
------------

// File: rtl/serial_to_parallel5_pkg.sv
// Shared constants, state encoding and parity helper for the serial-to-parallel collector.
// Pure declarations; no timing or flow control.
package serial_to_parallel5_pkg;

   localparam int WORD_W = 5;
   localparam int CNT_W  = 3;

   // 2'b11 is unused and recovers to ST_IDLE.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SHIFT  = 2'b01,
      ST_PARITY = 2'b10
   } state_t;

   function automatic logic parity_bit(input logic [WORD_W-1:0] word, input logic odd);
      return (^word) ^ odd;
   endfunction

endpackage

// File: rtl/serial_to_parallel5_shift_reg5_dir.sv
// 5-bit shift register with enable, synchronous clear and selectable shift direction.
// Latency: one clock from shift_en to q; q_nxt exposes the value q takes at the next edge.
// Backpressure: none; shifts whenever shift_en is high.
module shift_reg5_dir
   import serial_to_parallel5_pkg::*;
#(
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              shift_en,
   input  logic              bit_in,
   output logic [WORD_W-1:0] q,
   output logic [WORD_W-1:0] q_nxt
);

   always_comb begin
      q_nxt = q;
      if (clr) begin
         q_nxt = '0;
      end else if (shift_en) begin
         q_nxt = MSB_FIRST ? {q[WORD_W-2:0], bit_in} : {bit_in, q[WORD_W-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else begin
         q <= q_nxt;
      end
   end

endmodule

// File: rtl/serial_to_parallel5.sv
// Collects a framed serial stream (start, 5 data bits, optional parity) into a 5-bit word.
// Latency: load_en / parity_err rise one clock after the final accepted bit.
// Backpressure: none; bits are taken only when bit_valid is high, idle cycles just hold.
module serial_to_parallel5
   import serial_to_parallel5_pkg::*;
#(
   parameter bit PARITY_EN  = 1'b1,
   parameter bit ODD_PARITY = 1'b0,
   parameter bit MSB_FIRST  = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic              bit_valid,
   input  logic              bit_in,
   output logic              busy,
   output logic [WORD_W-1:0] data_out,
   output logic              load_en,
   output logic              parity_err
);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [WORD_W-1:0]  sr_q, sr_nxt;
   logic               sr_clr, shift_en, commit, perr;
   logic               last_bit, par_ok;

   assign last_bit = (cnt == CNT_W'(WORD_W - 1));
   assign par_ok   = (bit_in == parity_bit(sr_q, ODD_PARITY));
   assign busy     = (state != ST_IDLE);

   shift_reg5_dir #(
      .MSB_FIRST (MSB_FIRST)
   ) u_shift (
      .clk      (clk),
      .reset    (reset),
      .clr      (sr_clr),
      .shift_en (shift_en),
      .bit_in   (bit_in),
      .q        (sr_q),
      .q_nxt    (sr_nxt)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start && !abort) state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (abort) begin
               state_nxt = ST_IDLE;
            end else if (bit_valid && last_bit) begin
               state_nxt = PARITY_EN ? ST_PARITY : ST_IDLE;
            end
         end
         ST_PARITY: begin
            if (abort || bit_valid) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // abort always beats the completing bit, so every strobe below is gated by !abort.
   always_comb begin
      sr_clr   = 1'b0;
      shift_en = 1'b0;
      commit   = 1'b0;
      perr     = 1'b0;
      cnt_nxt  = cnt;
      case (state)
         ST_IDLE: begin
            if (start && !abort) begin
               sr_clr  = 1'b1;
               cnt_nxt = '0;
            end
         end
         ST_SHIFT: begin
            if (abort) begin
               cnt_nxt = '0;
            end else if (bit_valid) begin
               shift_en = 1'b1;
               cnt_nxt  = last_bit ? '0 : cnt + 1'b1;
               commit   = last_bit && !PARITY_EN;
            end
         end
         ST_PARITY: begin
            if (abort) begin
               cnt_nxt = '0;
            end else if (bit_valid) begin
               commit = par_ok;
               perr   = !par_ok;
            end
         end
         default: cnt_nxt = '0;
      endcase
   end

   // sr_nxt already holds the final shifted bit when committing straight from SHIFT.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_out   <= '0;
         load_en    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         load_en    <= commit;
         parity_err <= perr;
         if (commit) data_out <= sr_nxt;
      end
   end

endmodule

// File: tb/tb_serial_to_parallel5.sv
// Drives three parameter variants with shared stimulus and checks every output each cycle
// against a frame-level model, plus directed scenario checks.
module tb_serial_to_parallel5;

   localparam int NDUT = 3;
   // variant i: bit i of each vector holds that parameter for DUT i
   localparam bit [2:0] PE_V  = 3'b101;
   localparam bit [2:0] MSB_V = 3'b110;
   localparam bit [2:0] ODD_V = 3'b100;

   logic clk;
   logic rst, st, ab, bv, bi;

   logic       busy_o [NDUT];
   logic [4:0] data_o [NDUT];
   logic       load_o [NDUT];
   logic       perr_o [NDUT];

   int n_chk;
   int n_err;

   bit       m_act  [NDUT];
   int       m_cnt  [NDUT];
   bit       m_bits [NDUT][5];
   bit [4:0] m_data [NDUT];
   bit       m_load [NDUT];
   bit       m_perr [NDUT];

   serial_to_parallel5 #(.PARITY_EN(1'b1), .ODD_PARITY(1'b0), .MSB_FIRST(1'b0)) u_dut0 (
      .clk(clk), .reset(rst), .start(st), .abort(ab), .bit_valid(bv), .bit_in(bi),
      .busy(busy_o[0]), .data_out(data_o[0]), .load_en(load_o[0]), .parity_err(perr_o[0])
   );

   serial_to_parallel5 #(.PARITY_EN(1'b0), .ODD_PARITY(1'b0), .MSB_FIRST(1'b1)) u_dut1 (
      .clk(clk), .reset(rst), .start(st), .abort(ab), .bit_valid(bv), .bit_in(bi),
      .busy(busy_o[1]), .data_out(data_o[1]), .load_en(load_o[1]), .parity_err(perr_o[1])
   );

   serial_to_parallel5 #(.PARITY_EN(1'b1), .ODD_PARITY(1'b1), .MSB_FIRST(1'b1)) u_dut2 (
      .clk(clk), .reset(rst), .start(st), .abort(ab), .bit_valid(bv), .bit_in(bi),
      .busy(busy_o[2]), .data_out(data_o[2]), .load_en(load_o[2]), .parity_err(perr_o[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit [4:0] word_of(input int i);
      bit [4:0] w;
      w = '0;
      for (int k = 0; k < 5; k++) begin
         if (MSB_V[i]) w[4-k] = m_bits[i][k];
         else          w[k]   = m_bits[i][k];
      end
      return w;
   endfunction

   task automatic model_commit(input int i);
      m_data[i] = word_of(i);
      m_load[i] = 1'b1;
      m_act[i]  = 1'b0;
   endtask

   task automatic model_step(input int i);
      bit [4:0] w;
      bit       p;
      m_load[i] = 1'b0;
      m_perr[i] = 1'b0;
      if (rst) begin
         m_act[i]  = 1'b0;
         m_cnt[i]  = 0;
         m_data[i] = '0;
      end else if (!m_act[i]) begin
         if (st && !ab) begin
            m_act[i] = 1'b1;
            m_cnt[i] = 0;
         end
      end else if (ab) begin
         m_act[i] = 1'b0;
      end else if (bv) begin
         if (m_cnt[i] < 5) begin
            m_bits[i][m_cnt[i]] = bi;
            m_cnt[i]++;
            if (m_cnt[i] == 5 && !PE_V[i]) model_commit(i);
         end else begin
            w = word_of(i);
            p = 1'($countones(w) % 2) ^ ODD_V[i];
            if (bi == p) model_commit(i);
            else         m_perr[i] = 1'b1;
            m_act[i] = 1'b0;
         end
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < NDUT; i++) begin
         check_val($sformatf("d%0d_busy", i), 32'(busy_o[i]), 32'(m_act[i]));
         check_val($sformatf("d%0d_data", i), 32'(data_o[i]), 32'(m_data[i]));
         check_val($sformatf("d%0d_load", i), 32'(load_o[i]), 32'(m_load[i]));
         check_val($sformatf("d%0d_perr", i), 32'(perr_o[i]), 32'(m_perr[i]));
      end
   endtask

   task automatic step(input logic r, input logic s, input logic a, input logic v, input logic b);
      rst = r; st = s; ab = a; bv = v; bi = b;
      @(posedge clk);
      for (int i = 0; i < NDUT; i++) model_step(i);
      #1;
      compare_all();
   endtask

   // seq[0] is sent first
   task automatic send_bits(input bit [4:0] seq);
      for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 1'b1, seq[k]);
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      for (int i = 0; i < NDUT; i++) begin
         m_act[i] = 0; m_cnt[i] = 0; m_data[i] = '0; m_load[i] = 0; m_perr[i] = 0;
         for (int k = 0; k < 5; k++) m_bits[i][k] = 0;
      end
      rst = 1'b1; st = 1'b0; ab = 1'b0; bv = 1'b0; bi = 1'b0;

      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      check_val("rst_data", 32'(data_o[0]), 32'h0);
      check_val("rst_busy", 32'(busy_o[0]), 32'h0);

      // even parity, LSB first: 1,0,1,1,0 + parity 1
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      send_bits(5'b01101);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check_val("tp1_data", 32'(data_o[0]), 32'h0D);
      check_val("tp1_load", 32'(load_o[0]), 32'h1);
      check_val("tp1_perr", 32'(perr_o[0]), 32'h0);
      check_val("tp1_busy", 32'(busy_o[0]), 32'h0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_val("tp1_load_drop", 32'(load_o[0]), 32'h0);

      // same data, wrong parity
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      send_bits(5'b01101);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_val("tp2_perr", 32'(perr_o[0]), 32'h1);
      check_val("tp2_load", 32'(load_o[0]), 32'h0);
      check_val("tp2_data", 32'(data_o[0]), 32'h0D);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_val("tp2_perr_drop", 32'(perr_o[0]), 32'h0);

      // MSB first, no parity, 2-cycle gaps with bit_in held high while invalid
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1, (k == 0 || k == 4) ? 1'b1 : 1'b0);
         if (k < 4) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         end
      end
      check_val("tp3_data", 32'(data_o[1]), 32'h11);
      check_val("tp3_load", 32'(load_o[1]), 32'h1);

      // abort together with the 5th bit
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      check_val("tp4_load", 32'(load_o[0]), 32'h0);
      check_val("tp4_perr", 32'(perr_o[0]), 32'h0);
      check_val("tp4_busy", 32'(busy_o[0]), 32'h0);
      check_val("tp4_data", 32'(data_o[0]), 32'h0D);

      // start+bit collision, then ignored mid-frame start
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      send_bits(5'b00000);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_val("tp5_data", 32'(data_o[0]), 32'h00);
      check_val("tp5_load", 32'(load_o[0]), 32'h1);

      // reset mid-frame, then a fresh frame
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check_val("tp6_busy", 32'(busy_o[0]), 32'h0);
      check_val("tp6_data", 32'(data_o[0]), 32'h00);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      send_bits(5'b01010);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_val("tp6_frame", 32'(data_o[0]), 32'h0A);
      check_val("tp6_load", 32'(load_o[0]), 32'h1);

      for (int n = 0; n < 4000; n++) begin
         step($urandom_range(0, 199) < 1,
              $urandom_range(0, 99) < 25,
              $urandom_range(0, 99) < 4,
              $urandom_range(0, 99) < 60,
              1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
